// File: rtl/pi_level_arbiter.sv
// -----------------------------------------------------------------------------
// pi_level_arbiter
// Priority-interrupt level arbiter for the EBOX PI path. Collects requests on
// levels 1..7 (level 1 highest priority), tracks in-progress levels and offers
// the highest-priority eligible level with a registered enable and level code.
// en_o/sel_o drive a 3-to-8 decoder directly; code 0 is never offered.
//
// Optional feature macro: PI_REQ_SYNC_EN
//   defined   : req_i passes through a two-flop synchronizer per level
//   undefined : req_i is used directly (must be synchronous to clk)
//
// Ports
//   clk        in   system clock, all state changes on rising edge
//   rst_n      in   synchronous active-low reset
//   req_i      in   [1:7] request per level, level 1 highest priority
//   ack_i      in   EBOX accepts the currently offered level (pulse)
//   dismiss_i  in   EBOX finished the highest-priority held level (pulse)
//   en_o       out  offer valid, decoder enable
//   sel_o      out  [0:2] offered level number, bit 0 = MSB
//   held_o     out  [1:7] levels currently in progress
//   busy_o     out  OR of held_o
// -----------------------------------------------------------------------------
module pi_level_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:7] req_i,
    input  logic       ack_i,
    input  logic       dismiss_i,
    output logic       en_o,
    output logic [0:2] sel_o,
    output logic [1:7] held_o,
    output logic       busy_o
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [1:7] pend_q, pend_d;
    logic [1:7] held_q, held_d;
    logic [0:2] sel_q, sel_d;
    logic       en_q, en_d;
    logic       busy_q;

    logic [1:7] req_s;
    logic [1:7] elig_s;
    logic [0:2] winner_s;
    logic       win_found_s;
    logic [1:7] sel_mask_s;
    logic [1:7] dis_mask_s;
    logic [1:7] clr_s;
    logic [1:7] set_s;
    logic       offer_elig_s;

`ifdef PI_REQ_SYNC_EN
    logic [1:7] sync1_q;
    logic [1:7] sync2_q;

    // Two-flop synchronizer for asynchronous request inputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 7'b0;
            sync2_q <= 7'b0;
        end else begin
            sync1_q <= req_i;
            sync2_q <= sync1_q;
        end
    end

    assign req_s = sync2_q;
`else
    assign req_s = req_i;
`endif

    // Eligibility (pending and not blocked by any held level at or above it) and winner
    always_comb begin
        logic blocked;
        blocked     = 1'b0;
        elig_s      = 7'b0;
        winner_s    = 3'b000;
        win_found_s = 1'b0;
        for (int l = 1; l <= 7; l++) begin
            // A held level blocks itself as well as every lower-priority level.
            blocked   = blocked | held_q[l];
            elig_s[l] = pend_q[l] & ~blocked;
            if (elig_s[l] && !win_found_s) begin
                winner_s    = 3'(l);
                win_found_s = 1'b1;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // One-hot of the offered level and of the held level a dismiss retires
    always_comb begin
        logic seen;
        sel_mask_s = 7'b0;
        dis_mask_s = 7'b0;
        seen       = 1'b0;
        for (int l = 1; l <= 7; l++) begin
            sel_mask_s[l] = (sel_q == 3'(l));
            if (dismiss_i && held_q[l] && !seen) begin
                dis_mask_s[l] = 1'b1;
                seen          = 1'b1;
            end else begin
                dis_mask_s[l] = 1'b0;
            end
        end
        offer_elig_s = |(elig_s & sel_mask_s);
    end

    // Next-state logic for the offer FSM, pending and held registers
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        en_d    = en_q;
        clr_s   = 7'b0;
        set_s   = 7'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_found_s) begin
                    sel_d   = winner_s;
                    en_d    = 1'b1;
                    state_d = ST_OFFER;
                end else begin
                    en_d    = 1'b0;
                end
            end
            ST_OFFER: begin
                if (ack_i) begin
                    set_s   = sel_mask_s;
                    clr_s   = sel_mask_s;
                    en_d    = 1'b0;
                    state_d = ST_IDLE;
                end else if (win_found_s && (winner_s < sel_q)) begin
                    // Preemption: a higher-priority level replaces the offer.
                    sel_d   = winner_s;
                end else if (!offer_elig_s) begin
                    // Defensive withdrawal; sel keeps its last value.
                    en_d    = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    en_d    = 1'b1;
                end
            end
            default: begin
                en_d    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
        // A request arriving with its own clear keeps the level pending.
        pend_d = (pend_q & ~clr_s) | req_s;
        // Dismiss acts on the pre-edge held value; ack sets after it.
        held_d = (held_q & ~dis_mask_s) | set_s;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pend_q  <= 7'b0;
            held_q  <= 7'b0;
            sel_q   <= 3'b000;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            held_q  <= held_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            busy_q  <= |held_d;
        end
    end

    assign en_o   = en_q;
    assign sel_o  = sel_q;
    assign held_o = held_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_pi_level_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pi_level_arbiter
// Random stimulus against a level-set reference model; expected outputs for
// each clock edge are queued by the stimulus process and checked by a monitor.
// Honors PI_REQ_SYNC_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_pi_level_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:7] req;
    logic       ack;
    logic       dismiss;
    logic       en;
    logic [0:2] sel;
    logic [1:7] held;
    logic       busy;

    always #5 clk = ~clk;

    pi_level_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req),
        .ack_i     (ack),
        .dismiss_i (dismiss),
        .en_o      (en),
        .sel_o     (sel),
        .held_o    (held),
        .busy_o    (busy)
    );

    // Expected {en, sel, held, busy} after each edge
    logic [11:0] exp_q[$];
    int vectors     = 0;
    int miscompares = 0;

    // Reference model: sets of pending/held levels, offered level (0 = none)
    logic [1:7] pm;
    logic [1:7] hm;
    int         offer_m;
    int         sel_m;
    logic [1:7] s1_m;
    logic [1:7] s2_m;

    function automatic bit eligible(int o, logic [1:7] p, logic [1:7] h);
        if (o < 1 || o > 7) return 1'b0;
        for (int k = 1; k <= o; k++) begin
            if (h[k]) return 1'b0;
        end
        return p[o];
    endfunction

    task automatic model_step(input logic r, input logic [1:7] rq,
                              input logic a, input logic d);
        logic [1:7] rq_eff;
        logic [1:7] new_h;
        int         win;
        int         clr_lvl;
        bit         done;
        if (!r) begin
            pm = 7'b0; hm = 7'b0; offer_m = 0; sel_m = 0;
            s1_m = 7'b0; s2_m = 7'b0;
        end else begin
`ifdef PI_REQ_SYNC_EN
            rq_eff = s2_m;
            s2_m   = s1_m;
            s1_m   = rq;
`else
            rq_eff = rq;
`endif
            win = 0;
            for (int l = 7; l >= 1; l--) begin
                if (eligible(l, pm, hm)) win = l;
            end
            new_h = hm;
            done  = 1'b0;
            if (d) begin
                for (int l = 1; l <= 7; l++) begin
                    if (!done && new_h[l]) begin
                        new_h[l] = 1'b0;
                        done     = 1'b1;
                    end
                end
            end
            clr_lvl = 0;
            if (offer_m != 0) begin
                if (a) begin
                    new_h[offer_m] = 1'b1;
                    clr_lvl        = offer_m;
                    offer_m        = 0;
                end else if (win != 0 && win < offer_m) begin
                    offer_m = win;
                    sel_m   = win;
                end else if (!eligible(offer_m, pm, hm)) begin
                    offer_m = 0;
                end
            end else if (win != 0) begin
                offer_m = win;
                sel_m   = win;
            end
            for (int l = 1; l <= 7; l++) begin
                pm[l] = (pm[l] && l != clr_lvl) || rq_eff[l];
            end
            hm = new_h;
        end
        exp_q.push_back({(offer_m != 0), 3'(sel_m), hm, |hm});
    endtask

    task automatic drive(input logic r, input logic [1:7] rq,
                         input logic a, input logic d);
        @(negedge clk);
        rst_n   = r;
        req     = rq;
        ack     = a;
        dismiss = d;
        model_step(r, rq, a, d);
    endtask

    // Monitor: compare DUT outputs shortly after every edge
    initial begin
        logic [11:0] e;
        logic [11:0] got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {en, sel, held, busy};
                vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL outputs t=%0t: got en=%b sel=%0d held=%b busy=%b, expected en=%b sel=%0d held=%b busy=%b",
                             $time, got[11], got[10:8], got[7:1], got[0],
                             e[11], e[10:8], e[7:1], e[0]);
                end
            end
        end
    end

    // Stimulus
    initial begin
        logic [1:7] rq;
        logic       a;
        logic       d;
        logic       r;
        rst_n = 1'b0; req = 7'b0; ack = 1'b0; dismiss = 1'b0;
        pm = 7'b0; hm = 7'b0; offer_m = 0; sel_m = 0; s1_m = 7'b0; s2_m = 7'b0;

        // Reset held with every request asserted, then release
        repeat (3) drive(1'b0, 7'h7F, 1'b0, 1'b0);
        drive(1'b1, 7'h7F, 1'b0, 1'b0);
        repeat (6) drive(1'b1, 7'b0, 1'b0, 1'b0);

        // Same-cycle ack and dismiss, preemption and blocking arise in the random run
        for (int c = 0; c < 3000; c++) begin
            r  = ($urandom_range(0, 249) != 0);
            rq = 7'b0;
            for (int l = 1; l <= 7; l++) begin
                rq[l] = ($urandom_range(0, 11) == 0);
            end
            if (offer_m != 0) a = ($urandom_range(0, 2) == 0);
            else              a = ($urandom_range(0, 9) == 0);
            d = ($urandom_range(0, 6) == 0);
            drive(r, rq, a, d);
        end

        drive(1'b1, 7'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected outputs left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
